// File: rtl/sseg_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scanner_pkg
// Description : Shared constants for the eight-digit seven-segment scanner:
//               hex-to-segment table, segment bit positions, idle codes.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_scanner_pkg;

    // Segment bit positions inside the o_sseg byte
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // All digits dark / all segments dark (active-low outputs)
    localparam logic [7:0] ANODES_OFF = 8'hFF;
    localparam logic [7:0] SEGS_OFF   = 8'hFF;

    // Active-high g..a patterns, entry k is the glyph for hex digit k
    localparam logic [0:15][6:0] HEX_SEG_TABLE = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage : sseg_scanner_pkg
`default_nettype wire

// File: rtl/sseg_scanner_hex_to_sseg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_sseg
// Description : Purely combinational hex nibble to active-high g..a decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sseg
    import sseg_scanner_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] segs
);

    // Table lookup; every nibble value has a glyph so no default is needed
    always_comb begin
        segs = HEX_SEG_TABLE[hex];
    end

endmodule : hex_to_sseg
`default_nettype wire

// File: rtl/sseg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scanner
// Description : Time-multiplexed driver for eight common-anode hex digits.
//               A prescaler advances a digit index; the displayed word and
//               decimal points are captured once per frame so a frame never
//               mixes two input words.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scanner
    import sseg_scanner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_LZ    = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_value,
    input  logic [7:0]  i_dp,
    input  logic        i_en,
    output logic [7:0]  o_an,
    output logic [7:0]  o_sseg
);

    localparam int unsigned            PRESC_W   = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0]     PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [2:0]             LAST_DIG  = 3'd7;

    logic [PRESC_W-1:0] r_prescaler;
    logic [2:0]         r_index;
    logic [31:0]        r_snap_value;
    logic [7:0]         r_snap_dp;
    logic               r_load_pending;

    logic               w_tick;
    logic               w_frame_end;
    logic [31:0]        w_shifted;
    logic [3:0]         w_nibble;
    logic               w_upper_zero;
    logic               w_blank;
    logic [6:0]         w_segs;

    assign w_tick      = (r_prescaler == PRESC_MAX);
    assign w_frame_end = w_tick && (r_index == LAST_DIG);

    // Current digit's nibble and whether it and every higher nibble are zero
    assign w_shifted    = r_snap_value >> {r_index, 2'b00};
    assign w_nibble     = w_shifted[3:0];
    assign w_upper_zero = (w_shifted == 32'd0);
    assign w_blank      = (BLANK_LZ != 0) && (r_index != 3'd0) && w_upper_zero;

    hex_to_sseg u_hex_to_sseg (
        .hex  (w_nibble),
        .segs (w_segs)
    );

    // Free-running prescaler and digit index; they keep going while disabled
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prescaler <= '0;
            r_index     <= 3'd0;
        end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
            if (w_tick) begin
                r_index <= r_index + 3'd1;
            end
        end
    end

    // Frame snapshot: loaded right after reset and at each 7->0 wrap
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_snap_value   <= 32'd0;
            r_snap_dp      <= 8'd0;
            r_load_pending <= 1'b1;
        end else begin
            r_load_pending <= 1'b0;
            if (r_load_pending || w_frame_end) begin
                r_snap_value <= i_value;
                r_snap_dp    <= i_dp;
            end
        end
    end

    // Registered drive of anodes and segments from the current index/snapshot
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_an   <= ANODES_OFF;
            o_sseg <= SEGS_OFF;
        end else if (i_en) begin
            o_an           <= ~(8'b0000_0001 << r_index);
            o_sseg[SEG_DP] <= ~r_snap_dp[r_index];
            o_sseg[6:0]    <= w_blank ? SEGS_OFF[6:0] : ~w_segs;
        end else begin
            o_an   <= ANODES_OFF;
            o_sseg <= SEGS_OFF;
        end
    end

endmodule : sseg_scanner
`default_nettype wire

// File: tb/tb_sseg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scanner
// Description : Self-checking bench for sseg_scanner (REFRESH_DIV=4), one
//               instance without and one with leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scanner;

    localparam int RD    = 4;
    localparam int FRAME = 8 * RD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value = 32'd0;
    logic [7:0]  dp    = 8'd0;
    logic        en    = 1'b1;

    logic [7:0]  an0, seg0, an1, seg1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          edge_n = 0;
    int          m_idx;
    logic [31:0] m_val  = 32'd0;
    logic [7:0]  m_dp   = 8'd0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    sseg_scanner #(.REFRESH_DIV(RD), .BLANK_LZ(0)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_dp(dp),
        .i_en(en), .o_an(an0), .o_sseg(seg0)
    );

    sseg_scanner #(.REFRESH_DIV(RD), .BLANK_LZ(1)) u_dut_lz (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_dp(dp),
        .i_en(en), .o_an(an1), .o_sseg(seg1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input logic [31:0] v, input logic [7:0] d,
                                            input int idx, input logic e, input bit blank);
        logic [7:0] a;
        logic [6:0] s;
        logic [31:0] hi;
        if (!e) return 16'hFFFF;
        a = 8'hFF;
        a[idx] = 1'b0;
        hi = v >> (4 * idx);
        s = glyph(hi[3:0]);
        if (blank && idx > 0 && hi == 32'd0) s = 7'h00;
        return {a, ~d[idx], ~s};
    endfunction

    // Model: predict each edge's outputs, update snapshot like the display should
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            edge_n = 0;
            m_val  = 32'd0;
            m_dp   = 8'd0;
            q0.push_back(16'hFFFF);
            q1.push_back(16'hFFFF);
        end else begin
            edge_n++;
            m_idx = ((edge_n - 1) / RD) % 8;
            q0.push_back(exp_out(m_val, m_dp, m_idx, en, 1'b0));
            q1.push_back(exp_out(m_val, m_dp, m_idx, en, 1'b1));
            if (edge_n == 1 || (edge_n % FRAME) == 0) begin
                m_val = value;
                m_dp  = dp;
            end
        end
    end

    // Scoreboard: compare the prediction against DUT outputs mid-cycle
    initial forever begin
        @(negedge clk);
        if (q0.size() > 0) check("sb_plain", {an0, seg0}, q0.pop_front());
        if (q1.size() > 0) check("sb_blank", {an1, seg1}, q1.pop_front());
    end

    task automatic goto_edge(input int target);
        int i;
        i = 0;
        while (edge_n != target && i < 500) begin
            @(negedge clk);
            i++;
        end
        if (edge_n != target) check("goto_timeout", 16'(edge_n), 16'(target));
    endtask

    task automatic apply_reset(input logic [31:0] v, input logic [7:0] d);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_plain", {an0, seg0}, 16'hFFFF);
        check("rst_async_blank", {an1, seg1}, 16'hFFFF);
        @(negedge clk);
        #1 value = v;
        dp = d;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state and zero value
        repeat (3) @(negedge clk);
        check("rst_state", {an0, seg0}, 16'hFFFF);
        #1 rst_n = 1'b1;
        goto_edge(2);
        check("zero_first", {an0, seg0}, 16'hFEC0);
        goto_edge(6);
        check("zero_an1", {8'h00, an0}, 16'h00FD);
        goto_edge(30);
        check("zero_an7", {8'h00, an0}, 16'h007F);
        goto_edge(36);

        // All 16 glyphs across two words
        apply_reset(32'h89AB_CDEF, 8'h01);
        goto_edge(2);
        check("hex_dig0", {8'h00, seg0}, 16'h000E);
        goto_edge(30);
        check("hex_dig7", {8'h00, seg0}, 16'h0080);
        value = 32'h0123_4567;
        dp    = 8'h00;
        goto_edge(34);
        check("hex2_dig0", {8'h00, seg0}, 16'h00F8);
        goto_edge(62);
        check("hex2_dig7", {8'h00, seg0}, 16'h00C0);
        goto_edge(66);

        // Mid-frame change is deferred to the next frame
        apply_reset(32'h1111_1111, 8'h00);
        goto_edge(14);
        value = 32'h2222_2222;
        goto_edge(20);
        check("defer_dig4", {8'h00, seg0}, 16'h00F9);
        goto_edge(30);
        check("defer_dig7", {8'h00, seg0}, 16'h00F9);
        goto_edge(34);
        check("next_frame", {8'h00, seg0}, 16'h00A4);
        goto_edge(40);

        // Leading-zero blanking
        apply_reset(32'h0000_0050, 8'h00);
        goto_edge(2);
        check("lz_dig0", {8'h00, seg1}, 16'h00C0);
        goto_edge(6);
        check("lz_dig1", {8'h00, seg1}, 16'h0092);
        goto_edge(10);
        check("lz_dig2", {8'h00, seg1}, 16'h00FF);
        check("nolz_dig2", {8'h00, seg0}, 16'h00C0);
        goto_edge(30);
        check("lz_dig7", {8'h00, seg1}, 16'h00FF);
        dp = 8'h80;
        goto_edge(62);
        check("lz_dig7_dp", {8'h00, seg1}, 16'h007F);
        goto_edge(70);

        // Display disable keeps the scan running
        en = 1'b0;
        goto_edge(75);
        check("dis_plain", {an0, seg0}, 16'hFFFF);
        check("dis_blank", {an1, seg1}, 16'hFFFF);
        goto_edge(80);
        en = 1'b1;
        goto_edge(82);
        check("reen_an", {8'h00, an0}, 16'h00EF);

        // Reset mid-frame at digit 5
        goto_edge(86);
        check("pre_rst_an5", {8'h00, an0}, 16'h00DF);
        apply_reset(32'hDEAD_BEEF, 8'h01);
        goto_edge(2);
        check("post_rst_dig0", {an0, seg0}, 16'hFE0E);
        goto_edge(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sseg_scanner
`default_nettype wire
